master_port: RTL and testbench
==============================

MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, bus address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bus data width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum stall cycles per handshake phase (used only with the timeout feature).
REQ-004 SHALL use a single clock and a synchronous, active-high reset, as follows.
- clk  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
REQ-005 SHALL have these local request/response ports.
- req_valid  in  1  local request present
- req_ready  out  1  block accepts a request this cycle
- req_write  in  1  1 = write, 0 = read; sampled at acceptance
- req_addr  in  ADDR_WIDTH  target address; sampled at acceptance
- req_wdata  in  DATA_WIDTH  write data; sampled at acceptance
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid on reads
- rsp_err  out  1  timeout abort flag; valid with rsp_valid
REQ-006 SHALL have these serial bus ports toward the slave.
- read_en  out  1  read transaction in progress
- write_en  out  1  write transaction in progress
- master_valid  out  1  master drives a valid bit on tx_address/tx_data
- slave_ready  in  1  slave accepts the current bit
- tx_address  out  1  serial address, MSB first
- tx_data  out  1  serial write data, MSB first
- slave_valid  in  1  slave drives a valid bit on rx_data
- master_ready  out  1  master accepts the current rx_data bit
- rx_data  in  1  serial read data, MSB first

Function
REQ-007 SHALL implement FSM states IDLE, ADDR, WDATA, RDATA, DONE.
REQ-008 IDLE: req_ready=1; req_valid&&req_ready latches req_write/req_addr/req_wdata -> ADDR next cycle.
REQ-009 SHALL hold req_ready=0 in every state except IDLE; requests there are ignored.
REQ-010 read_en (read) or write_en (write) SHALL be 1 in ADDR, WDATA, RDATA and 0 in IDLE and DONE.
REQ-011 ADDR: master_valid=1, tx_address = current address bit; a bit transfers on a cycle with master_valid&&slave_ready; the shifter advances only on a transfer.
REQ-012 slave_ready=0 SHALL stall: tx_address holds its bit, master_valid stays 1, bit counter holds.
REQ-013 After ADDR_WIDTH transfers: write -> WDATA, read -> RDATA.
REQ-014 WDATA: same handshake as ADDR on tx_data, DATA_WIDTH bits MSB first, then -> DONE.
REQ-015 tx_address and tx_data SHALL be 0 outside their own phases; master_valid SHALL be 0 outside ADDR/WDATA.
REQ-016 RDATA: master_ready=1; rx_data shifted in MSB first on each cycle with slave_valid&&master_ready; after DATA_WIDTH bits -> DONE.
REQ-017 DONE: rsp_valid=1 for exactly one cycle, rsp_rdata = assembled byte (reads) or 0 (writes), rsp_err=0 -> IDLE.
REQ-018 Zero-stall latency: write acceptance at cycle N gives rsp_valid at cycle N+ADDR_WIDTH+DATA_WIDTH+1 (21 with defaults); read with continuous slave_valid is identical.
REQ-019 rsp_rdata SHALL hold its value until the next rsp_valid.

Reset
REQ-020 With reset=1 at a rising edge: state IDLE; req_ready=1 after the edge; counters, shifters, rsp_rdata, and all other outputs 0.
REQ-021 A reset during any non-IDLE state SHALL abandon the transaction without a rsp_valid pulse.

Configuration
REQ-022 Macro MASTER_PORT_TIMEOUT_EN defined: a stall counter clears on each transfer and on phase entry and increments on each stalled cycle in ADDR/WDATA/RDATA; reaching TIMEOUT -> DONE with rsp_err=1 and rsp_rdata=0.
REQ-023 Macro undefined: no stall counter; phases wait indefinitely; rsp_err tied to 0.

Verification
REQ-024 Write addr 0xA5C, data 0x3E, slave_ready held 1 -> tx_address 101001011100 then tx_data 00111110 on consecutive cycles; write_en high 20 cycles; rsp_valid at cycle 21, rsp_err=0.
REQ-025 Read addr 0x001, slave returns 0xC3 with slave_valid held 1 -> read_en high; rsp_valid with rsp_rdata=0xC3 at cycle 21.
REQ-026 Write with slave_ready low 3 cycles after address bit 4 -> bit 5 held 3 cycles; rsp_valid at cycle 24; no bits lost or duplicated.
REQ-027 Reset asserted mid-WDATA -> IDLE after the edge, all outputs 0, no rsp_valid; next request completes normally.
REQ-028 With MASTER_PORT_TIMEOUT_EN and TIMEOUT=4, read with slave_valid never asserted -> rsp_valid with rsp_err=1, rsp_rdata=0 after 4 stalled RDATA cycles; without the macro, still waiting after 1000 cycles.

Source files
------------

// File: rtl/master_port_if.sv
// Bundle of the local request/response handshake and the serial slave bus
// used by master_port. The master modport is the port's own view; the slave
// modport is the view of whatever sits on the other side.
interface master_port_if #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  read_en;
    logic                  write_en;
    logic                  master_valid;
    logic                  slave_ready;
    logic                  tx_address;
    logic                  tx_data;
    logic                  slave_valid;
    logic                  master_ready;
    logic                  rx_data;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  slave_ready, slave_valid, rx_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output read_en, write_en, master_valid, tx_address, tx_data, master_ready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output slave_ready, slave_valid, rx_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  read_en, write_en, master_valid, tx_address, tx_data, master_ready
    );
endinterface

// File: rtl/master_port.sv
// Serial bus master: accepts one local read/write request, shifts the address
// (and write data) out MSB first with a valid/ready bit handshake, shifts read
// data in, then reports completion with a one-cycle rsp_valid pulse.
// Optional stall timeout enabled by defining MASTER_PORT_TIMEOUT_EN.
module master_port #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    master_port_if.master bus
);
    localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);

    // A zero timeout would abort every stalled cycle before it could be counted.
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("master_port: TIMEOUT must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, DONE} state_t;

    state_t                state, state_nxt;
    logic                  is_write, is_write_nxt;
    logic [ADDR_WIDTH-1:0] addr_sr, addr_sr_nxt;
    logic [DATA_WIDTH-1:0] data_sr, data_sr_nxt;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
    logic                  busy_nxt;
    logic                  req_ready_nxt, rsp_valid_nxt, rsp_err_nxt;
    logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
    logic                  read_en_nxt, write_en_nxt, master_valid_nxt;
    logic                  tx_address_nxt, tx_data_nxt, master_ready_nxt;

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_cnt, stall_cnt_nxt;
    logic               stalled;
`endif

    // Next-state, datapath and next-output decode; outputs are registered from state_nxt.
    always_comb begin
        state_nxt     = state;
        is_write_nxt  = is_write;
        addr_sr_nxt   = addr_sr;
        data_sr_nxt   = data_sr;
        bit_cnt_nxt   = bit_cnt;
        rsp_rdata_nxt = bus.rsp_rdata;
        rsp_err_nxt   = 1'b0;

        unique case (state)
            IDLE: begin
                if (bus.req_valid && bus.req_ready) begin
                    is_write_nxt = bus.req_write;
                    addr_sr_nxt  = bus.req_addr;
                    data_sr_nxt  = bus.req_wdata;
                    bit_cnt_nxt  = '0;
                    state_nxt    = ADDR;
                end
            end
            ADDR: begin
                if (bus.master_valid && bus.slave_ready) begin
                    addr_sr_nxt = ADDR_WIDTH'({addr_sr, 1'b0});
                    if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = is_write ? WDATA : RDATA;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            WDATA: begin
                if (bus.master_valid && bus.slave_ready) begin
                    data_sr_nxt = DATA_WIDTH'({data_sr, 1'b0});
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_nxt   = '0;
                        state_nxt     = DONE;
                        rsp_rdata_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            RDATA: begin
                if (bus.slave_valid && bus.master_ready) begin
                    data_sr_nxt = DATA_WIDTH'({data_sr, bus.rx_data});
                    if (bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_nxt   = '0;
                        state_nxt     = DONE;
                        rsp_rdata_nxt = DATA_WIDTH'({data_sr, bus.rx_data});
                    end else begin
                        bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef MASTER_PORT_TIMEOUT_EN
        // Stall counter restarts on every transfer and on phase entry.
        stalled = ((state == ADDR || state == WDATA) && !bus.slave_ready) ||
                  ((state == RDATA) && !bus.slave_valid);
        stall_cnt_nxt = '0;
        if (stalled) begin
            if (stall_cnt == STALL_W'(TIMEOUT - 1)) begin
                state_nxt     = DONE;
                rsp_err_nxt   = 1'b1;
                rsp_rdata_nxt = '0;
            end else begin
                stall_cnt_nxt = stall_cnt + STALL_W'(1);
            end
        end
`endif

        busy_nxt         = (state_nxt == ADDR) || (state_nxt == WDATA) || (state_nxt == RDATA);
        req_ready_nxt    = (state_nxt == IDLE);
        write_en_nxt     = busy_nxt && is_write_nxt;
        read_en_nxt      = busy_nxt && !is_write_nxt;
        master_valid_nxt = (state_nxt == ADDR) || (state_nxt == WDATA);
        tx_address_nxt   = (state_nxt == ADDR) && addr_sr_nxt[ADDR_WIDTH-1];
        tx_data_nxt      = (state_nxt == WDATA) && data_sr_nxt[DATA_WIDTH-1];
        master_ready_nxt = (state_nxt == RDATA);
        rsp_valid_nxt    = (state_nxt == DONE);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            is_write         <= 1'b0;
            addr_sr          <= '0;
            data_sr          <= '0;
            bit_cnt          <= '0;
            bus.req_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_rdata    <= '0;
            bus.rsp_err      <= 1'b0;
            bus.read_en      <= 1'b0;
            bus.write_en     <= 1'b0;
            bus.master_valid <= 1'b0;
            bus.tx_address   <= 1'b0;
            bus.tx_data      <= 1'b0;
            bus.master_ready <= 1'b0;
        end else begin
            state            <= state_nxt;
            is_write         <= is_write_nxt;
            addr_sr          <= addr_sr_nxt;
            data_sr          <= data_sr_nxt;
            bit_cnt          <= bit_cnt_nxt;
            bus.req_ready    <= req_ready_nxt;
            bus.rsp_valid    <= rsp_valid_nxt;
            bus.rsp_rdata    <= rsp_rdata_nxt;
            bus.rsp_err      <= rsp_err_nxt;
            bus.read_en      <= read_en_nxt;
            bus.write_en     <= write_en_nxt;
            bus.master_valid <= master_valid_nxt;
            bus.tx_address   <= tx_address_nxt;
            bus.tx_data      <= tx_data_nxt;
            bus.master_ready <= master_ready_nxt;
        end
    end

`ifdef MASTER_PORT_TIMEOUT_EN
    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt_nxt;
        end
    end
`endif
endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: directed vector table, reset/stall corner sequences
// and random transactions against a slave model and a latency/data reference.
module tb_master_port;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned NB    = AW + DW;
    localparam int          BOUND = 400;

    logic clk;
    logic reset;

    master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] sdata;
        int            stall_bit;
        int            stall_len;
        logic [DW-1:0] exp_rdata;
        int            exp_lat;
    } vec_t;

    vec_t tbl [6];
    int   stl [NB];

    localparam logic [31:0] RESET_OUTS = 32'h0001_0000;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] outs();
        return 32'({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.read_en,
                    bus.write_en, bus.master_valid, bus.tx_address, bus.tx_data, bus.master_ready});
    endfunction

    // One transaction: slave model stalls bit k for st[k] cycles before accepting it.
    task automatic run_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] sdata,
                           input int st [NB], input logic [DW-1:0] exp_rdata, input int exp_lat);
        int cyc, k, pend, en_cnt, other_en, bad_bits, busy_ready;
        en_cnt = 0; other_en = 0; bad_bits = 0; busy_ready = 0; k = 0; pend = st[0];
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        // Keep requesting with junk while busy: it must be ignored.
        bus.req_write = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        for (cyc = 1; cyc <= BOUND; cyc++) begin
            if (bus.rsp_valid) break;
            if (wr ? bus.write_en : bus.read_en) en_cnt++;
            if (wr ? bus.read_en : bus.write_en) other_en++;
            if (bus.req_ready) busy_ready++;
            bus.slave_ready = 1'b0;
            bus.slave_valid = 1'b0;
            bus.rx_data     = 1'($urandom);
            if (bus.master_valid) begin
                if (k < int'(AW)) begin
                    if (bus.tx_address !== addr[AW-1-k] || bus.tx_data !== 1'b0) bad_bits++;
                end else if (wr && k < int'(NB)) begin
                    if (bus.tx_data !== wdata[DW-1-(k-AW)] || bus.tx_address !== 1'b0) bad_bits++;
                end else begin
                    bad_bits++;
                end
                if (pend > 0) pend--;
                else begin
                    bus.slave_ready = 1'b1;
                    k++;
                    pend = (k < int'(NB)) ? st[k] : 0;
                end
            end else if (bus.master_ready) begin
                if (bus.tx_address !== 1'b0 || bus.tx_data !== 1'b0) bad_bits++;
                if (!wr && k >= int'(AW) && k < int'(NB)) begin
                    if (pend > 0) pend--;
                    else begin
                        bus.slave_valid = 1'b1;
                        bus.rx_data     = sdata[DW-1-(k-AW)];
                        k++;
                        pend = (k < int'(NB)) ? st[k] : 0;
                    end
                end else begin
                    bad_bits++;
                end
            end
            @(posedge clk); #1;
        end
        bus.req_valid   = 1'b0;
        bus.slave_ready = 1'b0;
        bus.slave_valid = 1'b0;
        check({tag, "/finished"}, 32'(cyc <= BOUND), 32'd1);
        check({tag, "/latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "/bits"}, 32'(k), 32'(NB));
        check({tag, "/bit_values"}, 32'(bad_bits), 32'd0);
        check({tag, "/en_cycles"}, 32'(en_cnt), 32'(exp_lat - 1));
        check({tag, "/wrong_en"}, 32'(other_en), 32'd0);
        check({tag, "/ready_busy"}, 32'(busy_ready), 32'd0);
        check({tag, "/rdata"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
        check({tag, "/err"}, 32'(bus.rsp_err), 32'd0);
        @(posedge clk); #1;
        check({tag, "/pulse_end"}, 32'({bus.rsp_valid, bus.req_ready}), 32'b01);
        check({tag, "/rdata_hold"}, 32'(bus.rsp_rdata), 32'(exp_rdata));
    endtask

    initial begin
        int lat, pulses, sum;
        logic          err_seen;
        logic [DW-1:0] rd_seen;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, sd;

        tbl[0] = '{1'b1, 12'hA5C, 8'h3E, 8'h00, -1, 0, 8'h00, 21};
        tbl[1] = '{1'b0, 12'h001, 8'h77, 8'hC3, -1, 0, 8'hC3, 21};
        tbl[2] = '{1'b1, 12'hA5C, 8'h3E, 8'h00,  5, 3, 8'h00, 24};
        tbl[3] = '{1'b0, 12'hFFF, 8'h00, 8'h5A, 14, 2, 8'h5A, 23};
        tbl[4] = '{1'b1, 12'h000, 8'hFF, 8'h00, 12, 1, 8'h00, 22};
        tbl[5] = '{1'b0, 12'h800, 8'hAA, 8'h01, 19, 4, 8'h01, 25};

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.slave_ready = 1'b0; bus.slave_valid = 1'b0; bus.rx_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), RESET_OUTS);
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_outputs", outs(), RESET_OUTS);

        // Directed vector table.
        for (int i = 0; i < 6; i++) begin
            for (int b = 0; b < int'(NB); b++) stl[b] = (b == tbl[i].stall_bit) ? tbl[i].stall_len : 0;
            run_txn($sformatf("vec%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].sdata,
                    stl, tbl[i].exp_rdata, tbl[i].exp_lat);
        end

        // Reset in the middle of the write-data phase.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 12'hA5C; bus.req_wdata = 8'h3E;
        bus.slave_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midwdata_phase", 32'({bus.write_en, bus.master_valid, bus.tx_address}), 32'b110);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.slave_ready = 1'b0;
        check("midwdata_reset_outputs", outs(), RESET_OUTS);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.rsp_valid || !bus.req_ready) pulses++;
            @(posedge clk); #1;
        end
        check("midwdata_no_rsp", 32'(pulses), 32'd0);
        for (int b = 0; b < int'(NB); b++) stl[b] = 0;
        run_txn("after_reset", 1'b0, 12'h3C5, 8'h00, 8'h96, stl, 8'h96, 21);

        // Read whose slave never presents data.
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 12'h001;
        bus.slave_ready = 1'b1; bus.slave_valid = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0; pulses = 0; err_seen = 1'b0; rd_seen = '1;
        for (int c = 1; c <= 1000; c++) begin
            if (bus.rsp_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = c; err_seen = bus.rsp_err; rd_seen = bus.rsp_rdata;
                end
            end
            @(posedge clk); #1;
        end
`ifdef MASTER_PORT_TIMEOUT_EN
        check("timeout_latency", 32'(lat), 32'd17);
        check("timeout_pulses", 32'(pulses), 32'd1);
        check("timeout_err", 32'(err_seen), 32'd1);
        check("timeout_rdata", 32'(rd_seen), 32'd0);
`else
        check("no_timeout_pulses", 32'(pulses), 32'd0);
        check("no_timeout_waiting", 32'({bus.read_en, bus.master_ready, bus.req_ready}), 32'b110);
`endif
        bus.slave_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("recover_reset_outputs", outs(), RESET_OUTS);

        // Random transactions against the reference: latency = AW+DW+1+stalls.
        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom);
            a  = AW'($urandom);
            wd = DW'($urandom);
            sd = DW'($urandom);
            sum = 0;
            for (int b = 0; b < int'(NB); b++) begin
                stl[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                sum += stl[b];
            end
            run_txn($sformatf("rnd%0d", t), wr, a, wd, sd, stl, wr ? 8'h00 : sd, int'(NB) + 1 + sum);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
